// File: rtl/pokey_serin_rx_if.sv
// SERIN receiver bus: line/tick/CPU-control inputs and received-frame status.
interface pokey_serin_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic                 sin;
    logic                 bit_tick;
    logic                 rx_ack;
    logic                 skres;
    logic                 sync_rst;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_full;
    logic                 rx_done;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output en, sin, bit_tick, rx_ack, skres,
        input  sync_rst, rx_data, rx_full, rx_done, frame_err, overrun, busy
    );

    modport slave (
        input  en, sin, bit_tick, rx_ack, skres,
        output sync_rst, rx_data, rx_full, rx_done, frame_err, overrun, busy
    );
endinterface

// File: rtl/pokey_serin_rx.sv
// POKEY SERIN receiver: start/data/stop deserialiser clocked on the falling edge.
// Optional macro POKEY_SERIN_SYNC2_EN adds a synchroniser stage ahead of s_sin.
module pokey_serin_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             resn,
    pokey_serin_rx_if.slave  bus
);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, shift_next;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 done_q, done_d;
    logic                 sync_q, sync_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 s_sin_q;

`ifdef POKEY_SERIN_SYNC2_EN
    // meta_q and s_sin_q together form the two-stage synchroniser
    logic meta_q;
    always_ff @(negedge clk or negedge resn) begin
        if (!resn) begin
            meta_q  <= 1'b1;
            s_sin_q <= 1'b1;
        end else begin
            meta_q  <= bus.sin;
            s_sin_q <= meta_q;
        end
    end
`else
    always_ff @(negedge clk or negedge resn) begin
        if (!resn) s_sin_q <= 1'b1;
        else       s_sin_q <= bus.sin;
    end
`endif

    // LSB-first: new bit enters at the MSB and the register shifts right
    if (DATA_BITS == 1) begin : g_one
        assign shift_next = s_sin_q;
    end else begin : g_multi
        assign shift_next = {s_sin_q, shift_q[DATA_BITS-1:1]};
    end

    always_ff @(negedge clk or negedge resn) begin
        if (!resn) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        done_d  = 1'b0;
        sync_d  = 1'b0;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        // Clears first so that a same-cycle set below takes priority
        if (bus.skres) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (bus.rx_ack) full_d = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!s_sin_q) begin
                        sync_d  = 1'b1;
                        state_d = START;
                    end
                end
                START: begin
                    if (bus.bit_tick) begin
                        if (!s_sin_q) begin
                            state_d = DATA;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bus.bit_tick) begin
                        shift_d = shift_next;
                        if (cnt_q == CW'(DATA_BITS - 1)) state_d = STOP;
                        else                             cnt_d   = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bus.bit_tick) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        full_d  = 1'b1;
                        if (!s_sin_q)                  ferr_d = 1'b1;
                        if (full_q && !bus.rx_ack)     ovr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sync_rst  = sync_q;
    assign bus.rx_data   = data_q;
    assign bus.rx_full   = full_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
